// File: rtl/shader_pkg.sv
// Shared definitions for the shader sequencer.
//   - NUM_SHADERS_DEF : default number of shader programs
//   - SH_*            : shader program IDs as seen on shader_select
//   - press_state_t   : button press classifier states
//   - cnt_w()         : width of a counter that must hold 0..n-1 (min 1 bit)
package shader_pkg;

  localparam int NUM_SHADERS_DEF = 7;

  localparam logic [3:0] SH_HGRAD    = 4'd0;
  localparam logic [3:0] SH_VGRAD    = 4'd1;
  localparam logic [3:0] SH_RADIAL   = 4'd2;
  localparam logic [3:0] SH_CHECKER  = 4'd3;
  localparam logic [3:0] SH_SINE     = 4'd4;
  localparam logic [3:0] SH_SPIRAL   = 4'd5;
  localparam logic [3:0] SH_TRIANGLE = 4'd6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESSED,
    ST_HELD
  } press_state_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Button synchronizer + debouncer.
//   clk, rst  : pixel clock, async active-high reset
//   button_n  : raw active-low button, asynchronous to clk
//   btn       : debounced level, 1 = pressed
// The raw input passes a two-flop synchronizer (reset to the released
// level). The debounced level only flips after the synchronized level has
// disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
module button_debounce
  import shader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic clk,
  input  logic rst,
  input  logic button_n,
  output logic btn
);

  localparam int            CW      = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1, sync2;
  logic          level;
  logic [CW-1:0] cnt;

  assign level = ~sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      cnt   <= '0;
      btn   <= 1'b0;
    end else begin
      sync1 <= button_n;
      sync2 <= sync1;
      if (level != btn) begin
        // Counter never passes CNT_MAX: it clears on acceptance.
        if (cnt == CNT_MAX) begin
          btn <= level;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/shader_sequencer.sv
// Frame-synchronous shader program selector.
//   clk, rst       : pixel clock, async active-high reset
//   button_n       : raw active-low front-panel button
//   frame_start    : one-cycle pulse on the first cycle of every frame
//   shader_select  : committed shader index (changes only at frame start)
//   switch_pending : a new index is queued, waiting for frame_start
//   auto_mode      : auto-cycle mode active
// A short press advances to the next shader. With SHADER_SEQ_AUTO_EN
// defined, a long press toggles auto-cycle mode, which advances every
// AUTO_FRAMES frames. Without it, auto_mode is tied low and long presses
// are swallowed (the press FSM still passes through HELD).
module shader_sequencer
  import shader_pkg::*;
#(
  parameter int NUM_SHADERS       = NUM_SHADERS_DEF,
  parameter int DEBOUNCE_CYCLES   = 270000,
  parameter int LONG_PRESS_CYCLES = 27000000,
  parameter int AUTO_FRAMES       = 300
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       button_n,
  input  logic       frame_start,
  output logic [3:0] shader_select,
  output logic       switch_pending,
  output logic       auto_mode
);

  if (NUM_SHADERS < 2 || NUM_SHADERS > 16 || AUTO_FRAMES < 1 ||
      DEBOUNCE_CYCLES < 1 || LONG_PRESS_CYCLES < 1) begin : g_param_check
    $error("shader_sequencer: parameter out of range");
  end

  localparam int            HW       = cnt_w(LONG_PRESS_CYCLES);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_PRESS_CYCLES - 1);
  localparam logic [3:0]    IDX_MAX  = 4'(NUM_SHADERS - 1);

  logic          btn;
  press_state_t  state, state_nxt;
  logic [HW-1:0] hold_cnt;
  logic          short_fire, short_evt;
  logic          auto_adv, advance;
  logic [3:0]    next_idx;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .rst      (rst),
    .button_n (button_n),
    .btn      (btn)
  );

  // Press classifier. Release wins over long-press qualification when both
  // land in the same cycle.
  always_comb begin
    state_nxt  = state;
    short_fire = 1'b0;
    case (state)
      ST_IDLE:    if (btn) state_nxt = ST_PRESSED;
      ST_PRESSED: begin
        if (!btn) begin
          state_nxt  = ST_IDLE;
          short_fire = 1'b1;
        end else if (hold_cnt == HOLD_MAX) begin
          state_nxt = ST_HELD;
        end
      end
      ST_HELD:    if (!btn) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      hold_cnt  <= '0;
      short_evt <= 1'b0;
    end else begin
      state     <= state_nxt;
      short_evt <= short_fire;
      // Hold time is measured only while PRESSED; saturates at HOLD_MAX.
      if (state != ST_PRESSED)
        hold_cnt <= '0;
      else if (hold_cnt != HOLD_MAX)
        hold_cnt <= hold_cnt + 1'b1;
    end
  end

`ifdef SHADER_SEQ_AUTO_EN
  localparam int            FW        = cnt_w(AUTO_FRAMES);
  localparam logic [FW-1:0] FRAME_MAX = FW'(AUTO_FRAMES - 1);

  logic          long_evt;
  logic          auto_q;
  logic [FW-1:0] frame_cnt;

  assign auto_adv  = auto_q && frame_start && (frame_cnt == FRAME_MAX);
  assign auto_mode = auto_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      long_evt  <= 1'b0;
      auto_q    <= 1'b0;
      frame_cnt <= '0;
    end else begin
      long_evt <= (state == ST_PRESSED) && (state_nxt == ST_HELD);
      if (long_evt) begin
        auto_q    <= ~auto_q;
        frame_cnt <= '0;
      end else if (auto_q) begin
        // A manual advance restarts the dwell; expiry wraps to 0.
        if (short_evt || auto_adv)
          frame_cnt <= '0;
        else if (frame_start)
          frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end
`else
  assign auto_adv  = 1'b0;
  assign auto_mode = 1'b0;
`endif

  // Coincident sources collapse into a single advance.
  assign advance = short_evt | auto_adv;

  // Commit samples next_idx before this cycle's advance lands, so a
  // coincident advance stays pending for the following frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      next_idx       <= 4'd0;
      shader_select  <= 4'd0;
      switch_pending <= 1'b0;
    end else begin
      if (advance)
        next_idx <= (next_idx == IDX_MAX) ? 4'd0 : next_idx + 4'd1;
      if (frame_start && switch_pending)
        shader_select <= next_idx;
      if (advance)
        switch_pending <= 1'b1;
      else if (frame_start)
        switch_pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shader_sequencer.sv
// Bench for shader_sequencer with small timing parameters. A cycle-level
// reference model derived from the documented latencies runs alongside the
// DUT and is compared every cycle; directed literal checks pin the model.
module tb_shader_sequencer;

  localparam int NS = 7;
  localparam int DB = 4;
  localparam int LP = 20;
  localparam int AF = 3;
  localparam int FP = 50;
`ifdef SHADER_SEQ_AUTO_EN
  localparam int AUTO = 1;
`else
  localparam int AUTO = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       button_n = 1'b1;
  logic       frame_start = 1'b0;
  logic [3:0] shader_select;
  logic       switch_pending;
  logic       auto_mode;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic [3:0] m_sel = 4'd0;
  logic [3:0] m_next = 4'd0;
  logic       m_pend = 1'b0;
  logic       m_auto = 1'b0;
  int         m_fcnt = 0;
  bit         ev_short[int];  // edge number -> short_evt consumed at that edge
  bit         ev_tog[int];    // edge number -> auto_mode toggles at that edge

  shader_sequencer #(
    .NUM_SHADERS      (NS),
    .DEBOUNCE_CYCLES  (DB),
    .LONG_PRESS_CYCLES(LP),
    .AUTO_FRAMES      (AF)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .button_n      (button_n),
    .frame_start   (frame_start),
    .shader_select (shader_select),
    .switch_pending(switch_pending),
    .auto_mode     (auto_mode)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // frame_start is sampled high at every edge whose number is a multiple of FP.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      frame_start = ((cyc + 1) % FP == 0);
    end
  end

  // Model: advance/commit/auto rules applied per clock edge.
  initial begin
    int e;
    bit sh, fs, expire, adv;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_sel  = 4'd0;
        m_next = 4'd0;
        m_pend = 1'b0;
        m_auto = 1'b0;
        m_fcnt = 0;
      end else begin
        e      = cyc + 1;
        sh     = ev_short.exists(e);
        fs     = frame_start;
        expire = m_auto && fs && (m_fcnt + 1 == AF);
        adv    = sh || expire;
        if (fs && m_pend) m_sel = m_next;
        if (adv) begin
          m_pend = 1'b1;
          m_next = (m_next == NS - 1) ? 4'd0 : m_next + 4'd1;
        end else if (fs) begin
          m_pend = 1'b0;
        end
        if (AUTO != 0 && ev_tog.exists(e)) begin
          m_auto = !m_auto;
          m_fcnt = 0;
        end else if (m_auto) begin
          if (adv) m_fcnt = 0;
          else if (fs) m_fcnt = m_fcnt + 1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      checks++;
      if (shader_select !== m_sel || switch_pending !== m_pend || auto_mode !== m_auto) begin
        errors++;
        $display("FAIL cycle %0d: sel=%0d want %0d, pending=%0d want %0d, auto=%0d want %0d",
                 cyc, shader_select, m_sel, switch_pending, m_pend, auto_mode, m_auto);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Return just after clock edge n.
  task automatic at_cyc(input int n);
    if (cyc > n) begin
      checks++;
      errors++;
      $display("FAIL schedule: at cycle %0d, wanted %0d", cyc, n);
    end
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int next_frame();
    return FP * (cyc / FP + 1);
  endfunction

  // Press for len cycles starting after edge a; schedule the expected effect:
  // long press -> toggle 2+DB+1+(LP-1)+1+1 edges after the press,
  // short press -> advance 2+DB+1+1 edges after the release.
  task automatic press(input int a, input int len);
    at_cyc(a);
    button_n = 1'b0;
    if (len > LP) ev_tog[a + 2 + DB + 1 + (LP - 1) + 1 + 1] = 1'b1;
    else          ev_short[a + len + 2 + DB + 1 + 1] = 1'b1;
    at_cyc(a + len);
    button_n = 1'b1;
  endtask

  task automatic do_reset();
    int c;
    c = cyc;
    rst = 1'b1;
    at_cyc(c + 2);
    rst = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, a;

    at_cyc(2);
    chk("reset sel", shader_select, 0);
    chk("reset pending", switch_pending, 0);
    chk("reset auto", auto_mode, 0);
    rst = 1'b0;

    // Bounce rejection: two 2-cycle glitches, then a clean 10-cycle press.
    b = next_frame();
    a = b + 5;
    at_cyc(a);     button_n = 1'b0;
    at_cyc(a + 2); button_n = 1'b1;
    at_cyc(a + 4); button_n = 1'b0;
    at_cyc(a + 6); button_n = 1'b1;
    press(a + 10, 10);
    at_cyc(a + 29);
    chk("bounce pending before frame", switch_pending, 1);
    chk("bounce sel before frame", shader_select, 0);
    at_cyc(b + FP + 1);
    chk("bounce sel after frame", shader_select, 1);
    chk("bounce pending after frame", switch_pending, 0);
    at_cyc(b + 2 * FP + 1);
    chk("bounce single advance", shader_select, 1);

    // Wrap-around: one short press per frame.
    do_reset();
    b = next_frame();
    for (int i = 0; i < 7; i++) begin
      press(b + FP * i + 5, 10);
      at_cyc(b + FP * (i + 1) + 1);
      chk($sformatf("wrap sel %0d", i), shader_select, (i + 1) % NS);
    end

    // Long press: toggles auto mode, no advance; auto commit on 4th frame.
    do_reset();
    b = next_frame();
    press(b + 5, 30);
    at_cyc(b + 45);
    chk("long auto on", auto_mode, AUTO);
    chk("long no advance", switch_pending, 0);
    at_cyc(b + 3 * FP + 1);
    chk("auto sel before commit", shader_select, 0);
    chk("auto pending after 3rd frame", switch_pending, AUTO);
    at_cyc(b + 4 * FP + 1);
    chk("auto sel at 4th frame", shader_select, AUTO);
    press(b + 4 * FP + 5, 30);
    at_cyc(b + 4 * FP + 45);
    chk("long auto off", auto_mode, 0);

    // Short press lands on the same edge as the auto expiry.
    do_reset();
    b = next_frame();
    press(b + 5, 30);
    press(b + 3 * FP - 18, 10);
    at_cyc(b + 3 * FP + 1);
    chk("simul pending", switch_pending, 1);
    at_cyc(b + 4 * FP + 1);
    chk("simul single advance", shader_select, 1);

    // Advance coincident with frame_start while index 2 is pending.
    do_reset();
    b = next_frame();
    press(b + 2, 6);
    press(b + 18, 6);
    press(b + 36, 6);
    at_cyc(b + FP - 1);
    chk("frame-adv sel before", shader_select, 0);
    at_cyc(b + FP + 1);
    chk("frame-adv sel", shader_select, 2);
    chk("frame-adv still pending", switch_pending, 1);
    at_cyc(b + 2 * FP + 1);
    chk("frame-adv next sel", shader_select, 3);
    chk("frame-adv pending cleared", switch_pending, 0);

    // Reset while HELD in auto mode; release afterwards yields nothing.
    do_reset();
    b = next_frame();
    a = b + 5;
    at_cyc(a);
    button_n = 1'b0;
    ev_tog[a + 2 + DB + 1 + (LP - 1) + 1 + 1] = 1'b1;
    at_cyc(a + 29);
    chk("held auto before reset", auto_mode, AUTO);
    at_cyc(a + 30);
    rst = 1'b1;
    #1;
    chk("mid reset sel", shader_select, 0);
    chk("mid reset pending", switch_pending, 0);
    chk("mid reset auto", auto_mode, 0);
    at_cyc(a + 33);
    rst = 1'b0;
    at_cyc(a + 34);
    button_n = 1'b1;
    at_cyc(a + 80);
    chk("post reset no event", switch_pending, 0);
    chk("post reset sel", shader_select, 0);
    chk("post reset auto", auto_mode, 0);

    at_cyc(cyc + 5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
